regs_sweep: RTL
===============

# regs_sweep

Parametrised picoMIPS general-purpose register file: 2^AW × n registers, two combinational read ports and one independent write port.
- %0 optionally hardwired to zero.
- Same-cycle write-to-read bypass.
- Hardware clear sweep that zeroes every register one per cycle after reset or on request, with a busy flag that stalls the core.

It sits between the decoder (read/write addresses) and the ALU/writeback mux, replacing the fixed 32 × n file.

## Interface
Parameters:
- n, 8, data width in bits.
- AW, 5, address width; DEPTH = 2^AW registers.
- ZERO_R0, 1, 1 makes %0 read as zero and ignore writes.
- BYPASS, 1, 1 forwards Wdata to a read port addressing the register being written this cycle.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- w  in  1  write enable.
- Waddr  in  AW  write address.
- Wdata  in  n  write data.
- Raddr1, Raddr2  in  AW  read addresses.
- clr  in  1  request a full clear sweep.
- Rdata1, Rdata2  out  n  read data (combinational).
- busy  out  1  high while the sweep is running; the core must stall.
- werr  out  1  one-cycle pulse the cycle after a write was dropped.

## Operation
- States: CLEAR, READY. A pointer ptr (AW bits) is held in state.
- Reset (sampled at posedge): state ← CLEAR, ptr ← 0, werr ← 0. Reset dominates every other input. Holding reset keeps ptr at 0.
- CLEAR, each posedge:
  - gpr[ptr] ← 0; ptr ← ptr+1 (wraps).
  - If ptr == DEPTH−1 then state ← READY.
  - A sweep is exactly DEPTH writes.
- CLEAR, inputs:
  - clr is ignored; the sweep is not restarted.
  - w is dropped, werr ← 1 next cycle.
- CLEAR, reads: Rdata1/Rdata2 = 0 regardless of address or bypass.
- READY, each posedge:
  - If clr: state ← CLEAR, ptr ← 0. A w in the same cycle is dropped (werr pulses).
  - Else if w and !(ZERO_R0 && Waddr == 0): gpr[Waddr] ← Wdata.
  - werr ← 0 unless a write was dropped.
- READY, reads, per port k:
  - If ZERO_R0 and Raddrk == 0: 0.
  - Else if BYPASS, w, !clr, Waddrk match and the write is not suppressed: Wdata.
  - Else gpr[Raddrk].
- Both read ports may address the same register; both receive identical data.
- With ZERO_R0 = 0, %0 is an ordinary register; the sweep still clears it.
- busy = (state == CLEAR). It is combinational from state, i.e. registered timing.

## Timing
- Reset values after the reset edge:
  - busy = 1, werr = 0, Rdata* = 0.
  - Register contents are undefined until the sweep completes.
- Sweep latency: reset deasserted before edge E1 → registers 0..DEPTH−1 cleared on E1..E_DEPTH. Then:
  - busy low after E_DEPTH.
  - First accepted write on E_DEPTH+1.
- clr sampled at edge E in READY → busy high after E; busy low after E+DEPTH.
- Read latency is 0 cycles (combinational). Write is visible via the array from the next cycle, and via bypass in the same cycle.
- werr: a dropped write sampled at edge E → werr high for the cycle after E, low after E+1 unless another write is dropped.
- Reset mid-sweep: ptr returns to 0 and a full DEPTH-cycle sweep restarts after release.

## Structure
- Package regs_pkg:
  - typedef enum logic {CLEAR, READY} rf_state_t.
  - A localparam function depth(AW) = 1 << AW.
- Sub-module regs_clear_fsm(clk, reset, clr, busy, ptr, clr_we) owns the state register and pointer. The top owns the array, write mux, bypass and werr.
- The array is a plain n × DEPTH logic array, written from one always_ff. The write port is muxed: {clr_we, ptr, 0} or {w, Waddr, Wdata}.

## Test plan
- Reset 1 cycle, n=8, AW=5 → busy high exactly 32 cycles, then low. All 32 registers read 0 on both ports after busy falls.
- Write 8'hA5 to %3 with Raddr1=3 in the same cycle → Rdata1=A5 that cycle (bypass). Next cycle with w=0 → Rdata1=A5 from the array.
- Write 8'hFF to %0 → Rdata1 and Rdata2 with address 0 read 0 in that cycle and the next. With ZERO_R0=0, the value reads back as FF.
- After loading %1..%31 with their index, assert clr for 1 cycle → busy 32 cycles. A w asserted during that time → werr pulses once. Afterwards all registers read 0.
- Assert reset at sweep cycle 10 of 32 → busy remains high for 32 further cycles after release.
- Randomised against a reference model with AW=3, n=16: random w/addr/clr streams → Rdata and werr match every cycle.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared types and helpers for the sweeping register file.
package regs_pkg;

    typedef enum logic {CLEAR, READY} rf_state_t;

    // Number of registers addressed by an aw-bit address.
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/regs_clear_fsm.sv
// Clear-sweep controller: walks ptr over every register after reset or a clr request.
//
// state | meaning
// CLEAR | sweeping; gpr[ptr] is zeroed each cycle, core stalled
// READY | normal operation; writes accepted
module regs_clear_fsm
    import regs_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] ptr,
    output logic          clr_we
);

    localparam logic [AW-1:0] LAST = AW'(depth(AW) - 1);

    rf_state_t     state, state_nxt;
    logic [AW-1:0] ptr_nxt;

    // State and pointer registers; reset restarts a full sweep from register 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic; clr is only honoured once the current sweep has finished.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy      = (state == CLEAR);
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                ptr_nxt = ptr + AW'(1);
                if (ptr == LAST) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regs_sweep.sv
// General-purpose register file with two read ports, one write port,
// optional hardwired %0, write-to-read bypass and a hardware clear sweep.
module regs_sweep
    import regs_pkg::*;
#(
    parameter int n       = 8,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w,
    input  logic [AW-1:0] Waddr,
    input  logic [n-1:0]  Wdata,
    input  logic [AW-1:0] Raddr1,
    input  logic [AW-1:0] Raddr2,
    input  logic          clr,
    output logic [n-1:0]  Rdata1,
    output logic [n-1:0]  Rdata2,
    output logic          busy,
    output logic          werr
);

    localparam int DEPTH = depth(AW);

    logic [n-1:0]  gpr [DEPTH];
    logic [AW-1:0] ptr;
    logic          clr_we;
    logic          w_hits_r0;
    logic          w_drop;
    logic          w_ok;
    logic          we_m;
    logic [AW-1:0] wa_m;
    logic [n-1:0]  wd_m;

    regs_clear_fsm #(.AW(AW)) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .busy   (busy),
        .ptr    (ptr),
        .clr_we (clr_we)
    );

    // A write to a hardwired %0 is silently ignored; only writes lost to the
    // sweep (running or just requested) count as dropped.
    assign w_hits_r0 = ZERO_R0 && (Waddr == '0);
    assign w_drop    = w && (busy || clr);
    assign w_ok      = w && !busy && !clr && !w_hits_r0;

    // Single write port shared between the sweep and the core.
    always_comb begin
        we_m = w_ok;
        wa_m = Waddr;
        wd_m = Wdata;
        if (clr_we) begin
            we_m = 1'b1;
            wa_m = ptr;
            wd_m = '0;
        end
    end

    // Register array; reset blocks the port so nothing changes on the reset edge.
    always_ff @(posedge clk) begin
        if (!reset && we_m) begin
            gpr[wa_m] <= wd_m;
        end
    end

    // Dropped-write flag, valid for the cycle after the drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            werr <= 1'b0;
        end else begin
            werr <= w_drop;
        end
    end

    function automatic logic [n-1:0] read_port(input logic [AW-1:0] a);
        if (busy) begin
            return '0;
        end else if (ZERO_R0 && (a == '0)) begin
            return '0;
        end else if (BYPASS && w_ok && (Waddr == a)) begin
            return Wdata;
        end else begin
            return gpr[a];
        end
    endfunction

    assign Rdata1 = read_port(Raddr1);
    assign Rdata2 = read_port(Raddr2);

endmodule
